// File: rtl/mesh_egress_arbiter.sv
// -----------------------------------------------------------------------------
// mesh_egress_arbiter
// N-channel egress merger for mesh_gnrtr router terminals. Words popped from
// CHANNELS upstream FWFT FIFOs are buffered in per-channel circular FIFOs and
// merged onto one pndng/popin output port through a 1-entry output register,
// using round-robin (ARB_MODE=0) or fixed lowest-index priority (ARB_MODE=1).
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   in_data    : channel i word at [i*pckg_sz +: pckg_sz]
//   in_pndng   : upstream FIFO i non-empty
//   in_pop     : pop strobe to upstream i (combinational), word captured at edge
//   out_data   : registered output word
//   out_pndng  : out_data valid
//   out_popin  : downstream consumes out_data at this edge
//   out_ch     : source channel of out_data
//   fifo_full  : internal FIFO i holds fifo_depth entries
// -----------------------------------------------------------------------------
module mesh_egress_arbiter #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS*pckg_sz-1:0]   in_data,
  input  logic [CHANNELS-1:0]           in_pndng,
  output logic [CHANNELS-1:0]           in_pop,
  output logic [pckg_sz-1:0]            out_data,
  output logic                          out_pndng,
  input  logic                          out_popin,
  output logic [$clog2(CHANNELS)-1:0]   out_ch,
  output logic [CHANNELS-1:0]           fifo_full
);

  localparam int unsigned CH_W  = $clog2(CHANNELS);
  localparam int unsigned PTR_W = $clog2(fifo_depth);
  localparam int unsigned CNT_W = $clog2(fifo_depth + 1);

  logic [pckg_sz-1:0] mem    [CHANNELS][fifo_depth];
  logic [PTR_W-1:0]   wr_ptr [CHANNELS];
  logic [PTR_W-1:0]   rd_ptr [CHANNELS];
  logic [CNT_W-1:0]   count  [CHANNELS];
  logic [CNT_W-1:0]   count_nxt [CHANNELS];

  logic [CHANNELS-1:0] nonempty_c;
  logic [CHANNELS-1:0] pop_c;
  logic [CH_W-1:0]     grant_idx_c;
  logic                grant_vld_c;
  logic                load_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Upstream pop: accept whenever the buffer had room before this edge.
  assign in_pop = in_pndng & ~fifo_full & {CHANNELS{~reset}};

  // Occupancy decode and per-channel next count.
  always_comb begin
    nonempty_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      nonempty_c[i] = (count[i] != '0);
      count_nxt[i]  = count[i];
      if (in_pop[i] && !pop_c[i]) begin
        count_nxt[i] = count[i] + CNT_W'(1);
      end else if (!in_pop[i] && pop_c[i]) begin
        count_nxt[i] = count[i] - CNT_W'(1);
      end
    end
  end

  // Arbiter: selects grant_idx_c among non-empty FIFOs.
  generate
    if (ARB_MODE == 0) begin : g_rr
      logic [CH_W-1:0] rr_ptr;
      logic [CH_W-1:0] cand_c;

      // Search upward from rr_ptr with wrap; first non-empty channel wins.
      always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
          cand_c = CH_W'((32'(rr_ptr) + 32'(k)) % CHANNELS);
          if (!grant_vld_c && nonempty_c[cand_c]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = cand_c;
          end
        end
      end

      // Pointer moves past the winner only when a grant is taken.
      always_ff @(posedge clk) begin
        if (reset) begin
          rr_ptr <= '0;
        end else if (load_c) begin
          rr_ptr <= (grant_idx_c == CH_W'(CHANNELS - 1)) ? '0
                                                         : grant_idx_c + CH_W'(1);
        end
      end
    end else begin : g_fp
      // Descending scan so the lowest non-empty index is assigned last.
      always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
          if (nonempty_c[k]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = CH_W'(k);
          end
        end
      end
    end
  endgenerate

  // Output register reloads when empty or being drained this cycle.
  assign load_c = (~out_pndng | out_popin) & grant_vld_c;

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop_c[i] = load_c && (grant_idx_c == CH_W'(i));
    end
  end

  // FIFO pointers, counts and full flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      fifo_full <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_pop[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop_c[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        count[i]     <= count_nxt[i];
        fifo_full[i] <= (count_nxt[i] == CNT_W'(fifo_depth));
      end
    end
  end

  // FIFO storage; datapath only, no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_pop[i]) mem[i][wr_ptr[i]] <= in_data[i*pckg_sz +: pckg_sz];
    end
  end

  // Output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_pndng <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_c) begin
      out_pndng <= 1'b1;
      out_data  <= mem[grant_idx_c][rd_ptr[grant_idx_c]];
      out_ch    <= grant_idx_c;
    end else if (out_popin && out_pndng) begin
      out_pndng <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mesh_egress_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mesh_egress_arbiter
// Self-checking bench: one round-robin and one fixed-priority instance, each fed
// by a modelled FWFT upstream; output words checked against a scoreboard.
// -----------------------------------------------------------------------------
module tb_mesh_egress_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             out_popin;

  logic [NCH*W-1:0] in_data_rr, in_data_fp;
  logic [NCH-1:0]   in_pndng_rr, in_pndng_fp;
  logic [NCH-1:0]   in_pop_rr, in_pop_fp;
  logic [W-1:0]     out_data_rr, out_data_fp;
  logic             out_pndng_rr, out_pndng_fp;
  logic [1:0]       out_ch_rr, out_ch_fp;
  logic [NCH-1:0]   fifo_full_rr, fifo_full_fp;

  mesh_egress_arbiter #(.CHANNELS(NCH), .pckg_sz(W), .fifo_depth(4), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .in_data(in_data_rr), .in_pndng(in_pndng_rr),
    .in_pop(in_pop_rr), .out_data(out_data_rr), .out_pndng(out_pndng_rr),
    .out_popin(out_popin), .out_ch(out_ch_rr), .fifo_full(fifo_full_rr));

  mesh_egress_arbiter #(.CHANNELS(NCH), .pckg_sz(W), .fifo_depth(4), .ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .in_data(in_data_fp), .in_pndng(in_pndng_fp),
    .in_pop(in_pop_fp), .out_data(out_data_fp), .out_pndng(out_pndng_fp),
    .out_popin(out_popin), .out_ch(out_ch_fp), .fifo_full(fifo_full_fp));

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   ch;
  } exp_t;

  typedef struct {
    int           ch;
    logic [W-1:0] data;
    logic [1:0]   exp_ch;
    logic [W-1:0] exp_data;
  } vec_t;

  exp_t sb_rr[$];
  exp_t sb_fp[$];

  logic [W-1:0] up_mem [2][NCH][16];
  int           up_wr  [2][NCH];
  int           up_rd  [2][NCH];
  int           pops_rr[NCH];
  int           first_c[2];
  int           last_c [2];
  int           cycle;
  int           n_chk;
  int           n_fail;

  function automatic logic [W-1:0] word(input int c, input int k);
    return 40'hC0_0000_0000 | (W'(c) << 32) | W'(k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < NCH; c++) begin
      in_pndng_rr[c]        = up_rd[0][c] < up_wr[0][c];
      in_data_rr[c*W +: W]  = up_mem[0][c][4'(up_rd[0][c])];
      in_pndng_fp[c]        = up_rd[1][c] < up_wr[1][c];
      in_data_fp[c*W +: W]  = up_mem[1][c][4'(up_rd[1][c])];
    end
  endtask

  task automatic up_clear();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        up_wr[d][c] = 0;
        up_rd[d][c] = 0;
      end
    end
    for (int c = 0; c < NCH; c++) pops_rr[c] = 0;
    refresh();
  endtask

  task automatic push(input int d, input int c, input logic [W-1:0] w);
    up_mem[d][c][4'(up_wr[d][c])] = w;
    up_wr[d][c]++;
  endtask

  task automatic sb_check(input int d, input logic [W-1:0] data, input logic [1:0] ch);
    exp_t e;
    if (first_c[d] < 0) first_c[d] = cycle;
    last_c[d] = cycle;
    if (d == 0) begin
      if (sb_rr.size() == 0) begin
        chk("sb_rr_unexpected_word", {22'h0, data, ch}, 64'h0);
        return;
      end
      e = sb_rr.pop_front();
      chk("sb_rr_word", {22'h0, data, ch}, {22'h0, e.data, e.ch});
    end else begin
      if (sb_fp.size() == 0) begin
        chk("sb_fp_unexpected_word", {22'h0, data, ch}, 64'h0);
        return;
      end
      e = sb_fp.pop_front();
      chk("sb_fp_word", {22'h0, data, ch}, {22'h0, e.data, e.ch});
    end
  endtask

  // One clock: sample pre-edge state at negedge, update upstream after the edge.
  task automatic cyc();
    logic [NCH-1:0] p0, p1;
    logic           c0, c1;
    logic [W-1:0]   d0, d1;
    logic [1:0]     h0, h1;
    @(negedge clk);
    p0 = in_pop_rr;  p1 = in_pop_fp;
    c0 = out_pndng_rr & out_popin;
    c1 = out_pndng_fp & out_popin;
    d0 = out_data_rr; d1 = out_data_fp;
    h0 = out_ch_rr;   h1 = out_ch_fp;
    @(posedge clk);
    #1;
    cycle++;
    if (c0 === 1'b1) sb_check(0, d0, h0);
    if (c1 === 1'b1) sb_check(1, d1, h1);
    for (int c = 0; c < NCH; c++) begin
      if (p0[c] === 1'b1) begin
        up_rd[0][c]++;
        pops_rr[c]++;
      end
      if (p1[c] === 1'b1) up_rd[1][c]++;
    end
    refresh();
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && (sb_rr.size() != 0 || sb_fp.size() != 0); i++) cyc();
    chk({nm, "_rr_left"}, 64'(sb_rr.size()), 64'h0);
    chk({nm, "_fp_left"}, 64'(sb_fp.size()), 64'h0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    up_clear();
    sb_rr.delete();
    sb_fp.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[4];
    int   rr_seq[12];
    int   fp_seq[12];
    int   nk[2][NCH];

    vecs[0] = '{ch: 2, data: 40'hA5_0000_0001, exp_ch: 2'd2, exp_data: 40'hA5_0000_0001};
    vecs[1] = '{ch: 0, data: 40'h5A_DEAD_BEEF, exp_ch: 2'd0, exp_data: 40'h5A_DEAD_BEEF};
    vecs[2] = '{ch: 3, data: 40'hFF_FFFF_FFFF, exp_ch: 2'd3, exp_data: 40'hFF_FFFF_FFFF};
    vecs[3] = '{ch: 1, data: 40'h12_3456_789A, exp_ch: 2'd1, exp_data: 40'h12_3456_789A};
    rr_seq  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    fp_seq  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};

    n_chk = 0; n_fail = 0; cycle = 0;
    first_c = '{-1, -1}; last_c = '{0, 0};
    reset = 1'b1; out_popin = 1'b0;
    up_clear();

    // Reset held 3 cycles with every upstream pending.
    for (int c = 0; c < NCH; c++) push(0, c, word(c, 0));
    refresh();
    for (int r = 0; r < 3; r++) begin
      cyc();
      chk("rst_in_pop", 64'(in_pop_rr), 64'h0);
      chk("rst_out_pndng", 64'(out_pndng_rr), 64'h0);
      chk("rst_out_data", 64'(out_data_rr), 64'h0);
    end
    chk("rst_out_ch", 64'(out_ch_rr), 64'h0);
    chk("rst_fifo_full", 64'(fifo_full_rr), 64'h0);
    chk("rst_fp_out_pndng", 64'(out_pndng_fp), 64'h0);
    up_clear();
    reset = 1'b0;

    // Single-word transfers: pop at edge N, visible after edge N+1.
    for (int v = 0; v < 4; v++) begin
      out_popin = 1'b0;
      push(0, vecs[v].ch, vecs[v].data);
      sb_rr.push_back('{data: vecs[v].exp_data, ch: vecs[v].exp_ch});
      refresh();
      #1;
      chk("single_in_pop", 64'(in_pop_rr), 64'(4'b0001 << vecs[v].ch));
      cyc();
      chk("single_no_bypass", 64'(out_pndng_rr), 64'h0);
      cyc();
      chk("single_out_pndng", 64'(out_pndng_rr), 64'h1);
      chk("single_out_data", 64'(out_data_rr), 64'(vecs[v].exp_data));
      chk("single_out_ch", 64'(out_ch_rr), 64'(vecs[v].exp_ch));
      out_popin = 1'b1;
      cyc();
      chk("single_consumed", 64'(out_pndng_rr), 64'h0);
      out_popin = 1'b0;
      up_clear();
    end
    chk("single_sb_empty", 64'(sb_rr.size()), 64'h0);

    // Fairness vs fixed priority: 3 words on every channel, popin held high.
    reset_pulse();
    for (int c = 0; c < NCH; c++) begin
      nk[0][c] = 0; nk[1][c] = 0;
      for (int k = 0; k < 3; k++) begin
        push(0, c, word(c, k));
        push(1, c, word(c, k));
      end
    end
    for (int i = 0; i < 12; i++) begin
      sb_rr.push_back('{data: word(rr_seq[i], nk[0][rr_seq[i]]), ch: 2'(rr_seq[i])});
      nk[0][rr_seq[i]]++;
      sb_fp.push_back('{data: word(fp_seq[i], nk[1][fp_seq[i]]), ch: 2'(fp_seq[i])});
      nk[1][fp_seq[i]]++;
    end
    first_c = '{-1, -1};
    out_popin = 1'b1;
    refresh();
    drain("arb");
    chk("rr_one_per_cycle", 64'(last_c[0] - first_c[0]), 64'd11);
    chk("fp_one_per_cycle", 64'(last_c[1] - first_c[1]), 64'd11);

    // Backpressure: ch0 streams 6 words into a stalled output.
    out_popin = 1'b0;
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      push(0, 0, word(0, k));
      sb_rr.push_back('{data: word(0, k), ch: 2'd0});
    end
    refresh();
    repeat (8) cyc();
    chk("bp_captures", 64'(pops_rr[0]), 64'd5);
    chk("bp_fifo_full", 64'(fifo_full_rr), 64'h1);
    chk("bp_in_pop_stopped", 64'(in_pop_rr), 64'h0);
    chk("bp_out_pndng", 64'(out_pndng_rr), 64'h1);
    chk("bp_out_data", 64'(out_data_rr), 64'(word(0, 0)));
    out_popin = 1'b1;
    drain("bp");
    chk("bp_all_captured", 64'(pops_rr[0]), 64'd6);

    // Reset mid-stream discards buffered words; next word passes alone.
    out_popin = 1'b0;
    reset_pulse();
    for (int k = 0; k < 3; k++) push(0, 1, word(1, k));
    refresh();
    repeat (4) cyc();
    chk("mid_buffered", 64'(out_pndng_rr), 64'h1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_out_pndng", 64'(out_pndng_rr), 64'h0);
    chk("mid_rst_fifo_full", 64'(fifo_full_rr), 64'h0);
    reset = 1'b0;
    up_clear();
    push(0, 3, 40'h3C_0000_00AA);
    sb_rr.push_back('{data: 40'h3C_0000_00AA, ch: 2'd3});
    refresh();
    cyc();
    chk("mid_after_pop", 64'(out_pndng_rr), 64'h0);
    cyc();
    chk("mid_word_pndng", 64'(out_pndng_rr), 64'h1);
    chk("mid_word_data", 64'(out_data_rr), 64'h3C_0000_00AA);
    out_popin = 1'b1;
    cyc();
    chk("mid_word_alone", 64'(out_pndng_rr), 64'h0);
    out_popin = 1'b0;
    chk("mid_sb_empty", 64'(sb_rr.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
